// File: rtl/elastic_pipeline.sv
// Elastic valid/ready register pipeline: PIPE_DEPTH collapsing register stages with an
// optional one-entry skid buffer that registers the upstream ready path, plus synchronous flush.
module elastic_pipeline #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       PIPE_DEPTH = 1,
  parameter bit                REG_READY  = 1'b0,
  parameter bit                RST_EN     = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic                            valid_i,
  input  logic [DATA_W-1:0]               data_i,
  output logic                            ready_o,
  output logic                            valid_o,
  output logic [DATA_W-1:0]               data_o,
  input  logic                            ready_i,
  output logic [$clog2(PIPE_DEPTH+2)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(PIPE_DEPTH + 2);

  if (PIPE_DEPTH == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
    assign ready_o = ready_i;
    assign count_o = '0;
  end else begin : g_pipe
    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PIPE_DEPTH-1:0] valid_d;
    logic [PIPE_DEPTH-1:0] load;
    logic [DATA_W-1:0]     data_q [PIPE_DEPTH];
    logic [DATA_W-1:0]     data_d [PIPE_DEPTH];
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  skid_valid_d;
    logic [CntW-1:0]       count_q;
    logic [CntW-1:0]       count_d;

    // A stage may load when it is empty or its successor loads; walks back from the output.
    always_comb begin
      logic nxt;
      nxt = ready_i;
      for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
        nxt     = !valid_q[k] || nxt;
        load[k] = nxt;
      end
    end

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        if (load[k]) begin
          valid_d[k] = valid_q[k-1];
          if (valid_q[k-1]) begin
            data_d[k] = data_q[k-1];
          end
        end
      end
      // Flush drops every held beat but leaves the data registers untouched.
      if (flush_i) begin
        valid_d = '0;
        data_d  = data_q;
      end
    end

    always_comb begin
      count_d = CntW'(skid_valid_d);
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        count_d = count_d + CntW'(valid_d[k]);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        count_q <= '0;
      end else begin
        valid_q <= valid_d;
        count_q <= count_d;
      end
    end

    if (RST_EN) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            data_q[k] <= RST_VAL;
          end
        end else begin
          data_q <= data_d;
        end
      end
    end else begin : g_data_nrst
      always_ff @(posedge clk) begin
        data_q <= data_d;
      end
    end

    if (REG_READY) begin : g_skid
      logic              skid_valid_q;
      logic [DATA_W-1:0] skid_data_q;
      logic [DATA_W-1:0] skid_data_d;

      assign in_valid = skid_valid_q || valid_i;
      assign in_data  = skid_valid_q ? skid_data_q : data_i;
      assign ready_o  = !skid_valid_q;

      // Skid captures an accepted beat only when stage 0 is blocked, i.e. the pipe is full.
      always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
          if (load[0]) begin
            skid_valid_d = 1'b0;
          end
        end else if (valid_i && !load[0]) begin
          skid_valid_d = 1'b1;
          skid_data_d  = data_i;
        end
        if (flush_i) begin
          skid_valid_d = 1'b0;
          skid_data_d  = skid_data_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_valid_q <= 1'b0;
        end else begin
          skid_valid_q <= skid_valid_d;
        end
      end

      if (RST_EN) begin : g_skid_rst
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            skid_data_q <= RST_VAL;
          end else begin
            skid_data_q <= skid_data_d;
          end
        end
      end else begin : g_skid_nrst
        always_ff @(posedge clk) begin
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_noskid
      assign in_valid     = valid_i;
      assign in_data      = data_i;
      assign ready_o      = load[0];
      assign skid_valid_d = 1'b0;
    end

    assign valid_o = valid_q[PIPE_DEPTH-1];
    assign data_o  = data_q[PIPE_DEPTH-1];
    assign count_o = count_q;
  end

endmodule
